noise_bram_reader: RTL and testbench

NOISE_BRAM_READER -- requirements
Module: noise_bram_reader

---
 rtl/noise_pkg.sv | 19 +
 rtl/noise_bram_reader_if.sv | 25 ++
 rtl/noise_skid_fifo.sv | 46 ++++
 rtl/noise_bram_reader.sv | 106 ++++++++++
 tb/tb_noise_bram_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// Shared types and defaults for the noise-table BRAM reader.
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_LAT = 2;

  // One slot per in-flight read plus two so a full pipeline never stalls at ready=1.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/noise_bram_reader_if.sv
// BRAM read port plus the AXI-Stream sample output of the noise reader.
interface noise_bram_reader_if
  import noise_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output bram_en, bram_addr, m_tdata, m_tvalid, m_tlast,
    input  bram_dout, m_tready
  );

  modport slave (
    input  bram_en, bram_addr, m_tdata, m_tvalid, m_tlast,
    output bram_dout, m_tready
  );
endinterface

// File: rtl/noise_skid_fifo.sv
// Shift-register FIFO: head entry is always ent[0], so read data comes straight from flops.
module noise_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                       CLK,
  input  logic                       SCLR,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] ent;
  logic [CW-1:0]           cnt;
  logic                    pop;
  logic                    push;
  logic [CW-1:0]           wr_pos;

  assign pop    = rd_en && (cnt != '0);
  assign push   = wr_en && ((cnt != CW'(DEPTH)) || pop);
  assign wr_pos = pop ? (cnt - CW'(1)) : cnt;

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      ent <= '0;
      cnt <= '0;
    end else begin
      if (pop)
        ent <= ent >> W;
      // Later NBA wins, so a simultaneous push lands in the slot the shift vacated.
      if (push)
        ent[wr_pos[IW-1:0]] <= wr_data;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign rd_data = ent[0];
  assign valid   = (cnt != '0);
  assign count   = cnt;

endmodule

// File: rtl/noise_bram_reader.sv
// Streams a noise table from BRAM to the scale multiplier with credit-based flow control.
//   state | meaning
//   IDLE  | address at 0, waiting for enable with a non-zero table_len
//   RUN   | issuing reads whenever FIFO occupancy + in-flight leaves a free slot
//   DRAIN | no new reads; waiting for in-flight data to land and the FIFO to empty
module noise_bram_reader
  import noise_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                CLK,
  input  logic                SCLR,
  input  logic                enable,
  input  logic [ADDR_W:0]     table_len,
  output logic                busy,
  noise_bram_reader_if.master bus
);
  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int LW    = ADDR_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [LW-1:0]     len_q;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] dl_vld;
  logic [RD_LAT-1:0] dl_last;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       credit_used;
  logic              issue;
  logic              land;
  logic              at_end;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_out;

  assign at_end      = ({1'b0, addr} == (len_q - LW'(1)));
  assign credit_used = {1'b0, fifo_cnt} + {1'b0, inflight};
  assign land        = dl_vld[RD_LAT-1];

  always_ff @(posedge CLK) begin
    if (SCLR)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE:    if (enable && (table_len != '0)) state_nxt = RUN;
      RUN: begin
        issue = (credit_used < (CW+1)'(DEPTH));
        if (!enable) state_nxt = DRAIN;
      end
      DRAIN:   if ((inflight == '0) && !fifo_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      len_q    <= '0;
      addr     <= '0;
      dl_vld   <= '0;
      dl_last  <= '0;
      inflight <= '0;
    end else begin
      if ((state == IDLE) && (state_nxt == RUN))
        len_q <= table_len;
      if (state_nxt == IDLE)
        addr <= '0;
      else if (issue)
        addr <= at_end ? '0 : addr + ADDR_W'(1);
      // Delay line mirrors the BRAM pipeline so the tag lines up with bram_dout.
      dl_vld   <= RD_LAT'({dl_vld, issue});
      dl_last  <= RD_LAT'({dl_last, issue && at_end});
      inflight <= inflight + CW'(issue) - CW'(land);
    end
  end

  noise_skid_fifo #(
    .DEPTH(DEPTH),
    .W    (DATA_W + 1)
  ) u_fifo (
    .CLK     (CLK),
    .SCLR    (SCLR),
    .wr_en   (land),
    .wr_data ({dl_last[RD_LAT-1], bus.bram_dout}),
    .rd_en   (bus.m_tready),
    .rd_data (fifo_out),
    .valid   (fifo_valid),
    .count   (fifo_cnt)
  );

  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr;
  assign bus.m_tdata   = fifo_out[DATA_W-1:0];
  assign bus.m_tlast   = fifo_out[DATA_W];
  assign bus.m_tvalid  = fifo_valid;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_noise_bram_reader.sv
// Directed bench for the noise reader: main build at RD_LAT=2 plus RD_LAT=1/3 latency builds.
module tb_noise_bram_reader;

  logic        CLK;
  logic        SCLR;
  logic        enable;
  logic        en1;
  logic        en3;
  logic [10:0] table_len;
  logic        busy;
  logic        busy1;
  logic        busy3;

  int checks   = 0;
  int failures = 0;

  noise_bram_reader_if #(.ADDR_W(10), .DATA_W(32)) bus  ();
  noise_bram_reader_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
  noise_bram_reader_if #(.ADDR_W(10), .DATA_W(32)) bus3 ();

  noise_bram_reader #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) dut (
    .CLK(CLK), .SCLR(SCLR), .enable(enable), .table_len(table_len), .busy(busy), .bus(bus));
  noise_bram_reader #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) dut1 (
    .CLK(CLK), .SCLR(SCLR), .enable(en1), .table_len(table_len), .busy(busy1), .bus(bus1));
  noise_bram_reader #(.ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut3 (
    .CLK(CLK), .SCLR(SCLR), .enable(en3), .table_len(table_len), .busy(busy3), .bus(bus3));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // BRAM models: data = 0x1000 + addr, garbage when not strobed.
  logic [31:0] p1;
  logic [31:0] p2 [2];
  logic [31:0] p3 [3];

  always @(posedge CLK) begin
    p1    <= bus1.bram_en ? 32'h1000 + 32'(bus1.bram_addr) : 32'hDEAD_BEEF;
    p2[0] <= bus.bram_en  ? 32'h1000 + 32'(bus.bram_addr)  : 32'hDEAD_BEEF;
    p2[1] <= p2[0];
    p3[0] <= bus3.bram_en ? 32'h1000 + 32'(bus3.bram_addr) : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign bus1.bram_dout = p1;
  assign bus.bram_dout  = p2[1];
  assign bus3.bram_dout = p3[2];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic restart();
    SCLR = 1'b1; enable = 1'b0; en1 = 1'b0; en3 = 1'b0;
    bus.m_tready = 1'b0; bus1.m_tready = 1'b0; bus3.m_tready = 1'b0;
    cyc(); cyc();
    SCLR = 1'b0;
  endtask

  task automatic test_reset();
    SCLR = 1'b1; enable = 1'b1; table_len = 11'd4; bus.m_tready = 1'b1;
    cyc(); cyc(); cyc();
    #1;
    checks++; if (bus.bram_en !== 1'b0) begin failures++; $display("FAIL reset_bram_en: got %b expected 0", bus.bram_en); end
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (bus.m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b expected 0", bus.m_tlast); end
    checks++; if (bus.m_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h expected 0", bus.m_tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    SCLR = 1'b0; enable = 1'b0; bus.m_tready = 1'b0;
    cyc();
  endtask

  task automatic test_stream();
    int first;
    int n;
    restart();
    table_len = 11'd4; enable = 1'b1; bus.m_tready = 1'b1;
    first = -1; n = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc(); #1;
      if (first < 0 && bus.m_tvalid === 1'b1) first = k;
      if (first >= 0) begin
        checks++;
        if (bus.m_tvalid !== 1'b1) begin
          failures++; $display("FAIL stream_gap: cycle %0d tvalid %b expected 1", k, bus.m_tvalid);
        end else begin
          checks++;
          if (bus.m_tdata !== 32'h1000 + 32'(n % 4)) begin
            failures++; $display("FAIL stream_data: sample %0d got %h expected %h", n, bus.m_tdata, 32'h1000 + 32'(n % 4));
          end
          checks++;
          if (bus.m_tlast !== (n % 4 == 3)) begin
            failures++; $display("FAIL stream_last: sample %0d got %b expected %b", n, bus.m_tlast, (n % 4 == 3));
          end
          n++;
        end
      end
    end
    checks++; if (first != 4) begin failures++; $display("FAIL stream_first_valid: got cycle %0d expected 4", first); end
    enable = 1'b0;
  endtask

  task automatic test_latency();
    int f1, f3, n1, n3;
    restart();
    table_len = 11'd4; en1 = 1'b1; en3 = 1'b1; bus1.m_tready = 1'b1; bus3.m_tready = 1'b1;
    f1 = -1; f3 = -1; n1 = 0; n3 = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc(); #1;
      if (bus1.m_tvalid === 1'b1) begin
        if (f1 < 0) f1 = k;
        checks++;
        if (bus1.m_tdata !== 32'h1000 + 32'(n1 % 4)) begin
          failures++; $display("FAIL lat1_data: sample %0d got %h expected %h", n1, bus1.m_tdata, 32'h1000 + 32'(n1 % 4));
        end
        n1++;
      end
      if (bus3.m_tvalid === 1'b1) begin
        if (f3 < 0) f3 = k;
        checks++;
        if (bus3.m_tdata !== 32'h1000 + 32'(n3 % 4)) begin
          failures++; $display("FAIL lat3_data: sample %0d got %h expected %h", n3, bus3.m_tdata, 32'h1000 + 32'(n3 % 4));
        end
        n3++;
      end
    end
    checks++; if (f1 != 3) begin failures++; $display("FAIL lat1_first_valid: got cycle %0d expected 3", f1); end
    checks++; if (f3 != 5) begin failures++; $display("FAIL lat3_first_valid: got cycle %0d expected 5", f3); end
    checks++; if (n1 != 14) begin failures++; $display("FAIL lat1_count: got %0d samples expected 14", n1); end
    checks++; if (n3 != 12) begin failures++; $display("FAIL lat3_count: got %0d samples expected 12", n3); end
    en1 = 1'b0; en3 = 1'b0;
  endtask

  task automatic test_random();
    int outstanding, n;
    logic stall, prev_last;
    logic [31:0] prev_data;
    restart();
    table_len = 11'd4; enable = 1'b1;
    outstanding = 0; n = 0; stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      bus.m_tready = ($urandom_range(0, 9) < 3);
      #1;
      if (stall) begin
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev_data || bus.m_tlast !== prev_last) begin
          failures++; $display("FAIL rand_hold: cycle %0d got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                               k, bus.m_tvalid, bus.m_tdata, bus.m_tlast, prev_data, prev_last);
        end
      end
      if (bus.bram_en === 1'b1) begin
        checks++;
        if (outstanding >= 4) begin
          failures++; $display("FAIL rand_credit: cycle %0d read issued with %0d outstanding, required below 4", k, outstanding);
        end
        outstanding++;
      end
      if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
        checks++;
        if (bus.m_tdata !== 32'h1000 + 32'(n % 4) || bus.m_tlast !== (n % 4 == 3)) begin
          failures++; $display("FAIL rand_order: sample %0d got %h/%b expected %h/%b",
                               n, bus.m_tdata, bus.m_tlast, 32'h1000 + 32'(n % 4), (n % 4 == 3));
        end
        n++;
        outstanding--;
      end
      stall = (bus.m_tvalid === 1'b1) && (bus.m_tready !== 1'b1);
      prev_data = bus.m_tdata;
      prev_last = bus.m_tlast;
      cyc();
    end
    checks++; if (n < 200) begin failures++; $display("FAIL rand_throughput: got %0d samples expected at least 200", n); end
    enable = 1'b0;
  endtask

  task automatic test_drain();
    int issued, n, k, got;
    logic found;
    restart();
    table_len = 11'd4; enable = 1'b1; bus.m_tready = 1'b1;
    issued = 0; n = 0; k = 0;
    while (issued < 10 && k < 50) begin
      #1;
      if (bus.bram_en === 1'b1) issued++;
      if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
        checks++;
        if (bus.m_tdata !== 32'h1000 + 32'(n % 4)) begin
          failures++; $display("FAIL drain_run_data: sample %0d got %h expected %h", n, bus.m_tdata, 32'h1000 + 32'(n % 4));
        end
        n++;
      end
      cyc();
      k++;
    end
    checks++; if (issued != 10) begin failures++; $display("FAIL drain_issue_timeout: got %0d reads expected 10", issued); end
    bus.m_tready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (bus.bram_en === 1'b1) issued++;
      cyc();
    end
    checks++; if (issued - n != 4) begin failures++; $display("FAIL drain_credit_fill: got %0d outstanding expected 4", issued - n); end
    enable = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++; if (bus.bram_en !== 1'b0) begin failures++; $display("FAIL drain_no_issue: got %b expected 0", bus.bram_en); end
      cyc();
    end
    enable = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (bus.bram_en !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL drain_reenable: got bram_en=%b busy=%b expected 0 and 1", bus.bram_en, busy);
      end
      cyc();
    end
    enable = 1'b0;
    #1;
    checks++;
    if (bus.m_tvalid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL drain_buffered: got tvalid=%b busy=%b expected 1 and 1", bus.m_tvalid, busy);
    end
    bus.m_tready = 1'b1;
    got = 0;
    for (int j = 0; j < 12; j++) begin
      if (bus.m_tvalid === 1'b1) begin
        checks++;
        if (bus.m_tdata !== 32'h1000 + 32'(n % 4)) begin
          failures++; $display("FAIL drain_out_data: sample %0d got %h expected %h", n, bus.m_tdata, 32'h1000 + 32'(n % 4));
        end
        n++;
        got++;
      end
      cyc(); #1;
    end
    checks++; if (got != 4) begin failures++; $display("FAIL drain_out_count: got %0d samples expected 4", got); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_idle_busy: got %b expected 0", busy); end
    enable = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc(); #1;
      if (!found && bus.m_tvalid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (bus.m_tdata !== 32'h1000) begin failures++; $display("FAIL drain_restart_data: got %h expected 00001000", bus.m_tdata); end
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL drain_restart_timeout: got no sample expected 00001000"); end
    enable = 1'b0;
  endtask

  task automatic test_len_edge();
    int n;
    logic seen;
    restart();
    table_len = 11'd0; enable = 1'b1; bus.m_tready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      #1;
      checks++;
      if (bus.bram_en !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL len0_idle: got bram_en=%b busy=%b expected 0 and 0", bus.bram_en, busy);
      end
      cyc();
    end
    table_len = 11'd1;
    n = 0; seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      #1;
      if (bus.m_tvalid === 1'b1) seen = 1'b1;
      if (seen) begin
        checks++;
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h1000 || bus.m_tlast !== 1'b1) begin
          failures++; $display("FAIL len1_sample: cycle %0d got v=%b d=%h l=%b expected v=1 d=00001000 l=1",
                               j, bus.m_tvalid, bus.m_tdata, bus.m_tlast);
        end
        n++;
      end
      cyc();
    end
    checks++; if (n != 16) begin failures++; $display("FAIL len1_count: got %0d samples expected 16", n); end
    enable = 1'b0;
  endtask

  task automatic test_sclr_mid();
    int stale;
    logic found;
    restart();
    table_len = 11'd4; enable = 1'b1; bus.m_tready = 1'b0;
    for (int j = 0; j < 10; j++) cyc();
    enable = 1'b0;
    for (int j = 0; j < 3; j++) cyc();
    bus.m_tready = 1'b1;
    #1;
    checks++;
    if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'h1000) begin
      failures++; $display("FAIL sclr_pre_pop: got v=%b d=%h expected v=1 d=00001000", bus.m_tvalid, bus.m_tdata);
    end
    cyc();
    bus.m_tready = 1'b0;
    SCLR = 1'b1;
    cyc(); #1;
    checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL sclr_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sclr_busy: got %b expected 0", busy); end
    checks++; if (bus.m_tdata !== 32'h0) begin failures++; $display("FAIL sclr_tdata: got %h expected 0", bus.m_tdata); end
    SCLR = 1'b0; bus.m_tready = 1'b1;
    stale = 0;
    for (int j = 0; j < 10; j++) begin
      if (bus.m_tvalid !== 1'b0) stale++;
      cyc(); #1;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL sclr_stale: got %0d valid cycles expected 0", stale); end
    enable = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc(); #1;
      if (!found && bus.m_tvalid === 1'b1) begin
        found = 1'b1;
        checks++;
        if (bus.m_tdata !== 32'h1000) begin failures++; $display("FAIL sclr_restart_data: got %h expected 00001000", bus.m_tdata); end
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL sclr_restart_timeout: got no sample expected 00001000"); end
    enable = 1'b0;
  endtask

  initial begin
    SCLR = 1'b1; enable = 1'b0; en1 = 1'b0; en3 = 1'b0; table_len = '0;
    bus.m_tready = 1'b0; bus1.m_tready = 1'b0; bus3.m_tready = 1'b0;
    test_reset();
    test_stream();
    test_latency();
    test_random();
    test_drain();
    test_len_edge();
    test_sclr_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
